// File: rtl/ifu_prefetch_if.sv
// Fetch-stage bundle: redirect/stall controls, IROM port, decode handshake and perf taps.
// The master modport is the prefetch unit; slave is its environment.
interface ifu_prefetch_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] dnpc;
  logic              dnpc_flag;
  logic              stall;
  logic              irom_req;
  logic [ADDR_W-1:0] irom_addr;
  logic [31:0]       irom_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_snpc;
  logic [31:0]       perf_fetch_cnt;
  logic [31:0]       perf_redirect_cnt;

  modport master (
    input  dnpc, dnpc_flag, stall, irom_data, out_ready,
    output irom_req, irom_addr, out_valid, out_pc, out_inst, out_snpc,
           perf_fetch_cnt, perf_redirect_cnt
  );

  modport slave (
    output dnpc, dnpc_flag, stall, irom_data, out_ready,
    input  irom_req, irom_addr, out_valid, out_pc, out_inst, out_snpc,
           perf_fetch_cnt, perf_redirect_cnt
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Prefetching fetch stage: DEPTH-entry {pc, inst} queue in front of a 1-cycle IROM.
// Define IFU_PERF_EN to get pop/redirect counters; otherwise the perf ports read 0.
module ifu_prefetch #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4
) (
  input logic            clock,
  input logic            reset,
  ifu_prefetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc, req_pc, last_pc, last_snpc;
  logic [31:0]       last_inst;
  logic              inflight, discard, bubble;
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [31:0]       q_inst [DEPTH];
  logic              valid, pop, wr;
  logic [CW:0]       occ;
  logic              unused_dnpc_lsb;

  assign unused_dnpc_lsb = ^bus.dnpc[1:0];

  assign valid = (count != '0);
  assign pop   = valid & bus.out_ready & ~bus.stall & ~bus.dnpc_flag;
  assign wr    = inflight & ~discard & ~bus.dnpc_flag;

  // Occupancy after this cycle including the response still in flight, so a
  // new request never lands in a full queue.
  assign occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

  assign bus.irom_req  = ~reset & ~bus.dnpc_flag & ~bubble & (occ < (CW+1)'(DEPTH));
  assign bus.irom_addr = fetch_pc;

  // Head outputs hold the last shown value while the queue is empty.
  assign bus.out_valid = valid;
  assign bus.out_pc    = valid ? q_pc[rptr]        : last_pc;
  assign bus.out_inst  = valid ? q_inst[rptr]      : last_inst;
  assign bus.out_snpc  = valid ? q_pc[rptr] + STEP : last_snpc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RST_PC;
      req_pc    <= '0;
      inflight  <= 1'b0;
      discard   <= 1'b0;
      bubble    <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      last_pc   <= '0;
      last_inst <= '0;
      last_snpc <= '0;
    end else begin
      inflight  <= bus.irom_req;
      discard   <= bus.dnpc_flag;
      bubble    <= bus.dnpc_flag;
      last_pc   <= bus.out_pc;
      last_inst <= bus.out_inst;
      last_snpc <= bus.out_snpc;
      if (bus.dnpc_flag) begin
        fetch_pc <= {bus.dnpc[ADDR_W-1:2], 2'b00};
        count    <= '0;
        wptr     <= rptr;
      end else begin
        if (bus.irom_req) begin
          fetch_pc <= fetch_pc + STEP;
          req_pc   <= fetch_pc;
        end
        if (wr)  wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        count <= count + CW'(wr) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr) begin
      q_pc[wptr]   <= req_pc;
      q_inst[wptr] <= bus.irom_data;
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt, redirect_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (pop)           fetch_cnt    <= fetch_cnt + 32'd1;
      if (bus.dnpc_flag) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

  assign bus.perf_fetch_cnt    = fetch_cnt;
  assign bus.perf_redirect_cnt = redirect_cnt;
`else
  assign bus.perf_fetch_cnt    = '0;
  assign bus.perf_redirect_cnt = '0;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: cycle table for fill/stall/redirect, random traffic vs an
// ordering/latency model, and an 8-bit address-wrap instance.
module tb_ifu_prefetch;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rst8  = 1'b1;
  always #5 clock = ~clock;

  ifu_prefetch_if #(.ADDR_W(32)) bus ();
  ifu_prefetch_if #(.ADDR_W(8))  bus8 ();

  ifu_prefetch #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(4)) u_dut (
    .clock(clock), .reset(reset), .bus(bus));
  ifu_prefetch #(.ADDR_W(8), .RESET_PC(32'hF8), .DEPTH(4)) u_dut8 (
    .clock(clock), .reset(rst8), .bus(bus8));

  // Synchronous IROM models: inst = addr ^ A5A5_0000, one cycle after the request.
  always @(posedge clock) begin
    if (bus.irom_req)  bus.irom_data  <= bus.irom_addr ^ 32'hA5A5_0000;
    if (bus8.irom_req) bus8.irom_data <= {24'h0, bus8.irom_addr} ^ 32'hA5A5_0000;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] perf_exp(input int n);
`ifdef IFU_PERF_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  typedef struct {
    logic        rdy, stl, flg;
    logic [31:0] dnpc;
    logic        vld;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  localparam int NV = 40;
  vec_t tbl [NV];

  task automatic v(input int i, input logic rdy, input logic stl, input logic flg,
                   input logic [31:0] dnpc, input logic vld, input logic [31:0] pc,
                   input logic req, input logic [31:0] addr);
    tbl[i] = '{rdy, stl, flg, dnpc, vld, pc, req, addr};
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic flg, input logic [31:0] d);
    bus.out_ready = rdy;
    bus.stall     = stl;
    bus.dnpc_flag = flg;
    bus.dnpc      = d;
  endtask

  initial begin
    int npop, nred, age;
    logic [31:0] exp_pc;
    logic rdy, stl, flg, ev;
    logic [31:0] d;

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    bus8.out_ready = 1'b1; bus8.stall = 1'b0; bus8.dnpc_flag = 1'b0; bus8.dnpc = 8'h0;

    // Fill with ready low, drain, stall, redirects (incl. during stall and back-to-back).
    for (int i = 0;  i < 2;  i++) v(i, 0, 0, 0, 0, 0, 0,     1, 32'(i*4));
    for (int i = 2;  i < 4;  i++) v(i, 0, 0, 0, 0, 1, 0,     1, 32'(i*4));
    for (int i = 4;  i < 10; i++) v(i, 0, 0, 0, 0, 1, 0,     0, 32'd16);
    for (int i = 10; i < 16; i++) v(i, 1, 0, 0, 0, 1, 32'((i-10)*4), 1, 32'(16+(i-10)*4));
    for (int i = 16; i < 21; i++) v(i, 1, 1, 0, 0, 1, 32'd24, 0, 32'd40);
    v(21, 1, 0, 0, 0,        1, 32'd24,  1, 32'd40);
    v(22, 1, 0, 0, 0,        1, 32'd28,  1, 32'd44);
    v(23, 1, 0, 1, 32'h103,  1, 32'd32,  0, 32'd48);
    v(24, 1, 0, 0, 0,        0, 0,       0, 32'h100);
    v(25, 1, 0, 0, 0,        0, 0,       1, 32'h100);
    v(26, 1, 0, 0, 0,        0, 0,       1, 32'h104);
    v(27, 1, 0, 0, 0,        1, 32'h100, 1, 32'h108);
    v(28, 1, 0, 0, 0,        1, 32'h104, 1, 32'h10C);
    v(29, 1, 1, 1, 32'h200,  1, 32'h108, 0, 32'h110);
    v(30, 1, 0, 0, 0,        0, 0,       0, 32'h200);
    v(31, 1, 0, 0, 0,        0, 0,       1, 32'h200);
    v(32, 1, 0, 0, 0,        0, 0,       1, 32'h204);
    v(33, 1, 0, 0, 0,        1, 32'h200, 1, 32'h208);
    v(34, 1, 0, 1, 32'h300,  1, 32'h204, 0, 32'h20C);
    v(35, 1, 0, 1, 32'h404,  0, 0,       0, 32'h300);
    v(36, 1, 0, 0, 0,        0, 0,       0, 32'h404);
    v(37, 1, 0, 0, 0,        0, 0,       1, 32'h404);
    v(38, 1, 0, 0, 0,        0, 0,       1, 32'h408);
    v(39, 1, 0, 0, 0,        1, 32'h404, 1, 32'h40C);

    repeat (2) @(negedge clock);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_req",   32'(bus.irom_req),  0);
    chk("rst_pc",    bus.out_pc,   0);
    chk("rst_inst",  bus.out_inst, 0);
    chk("rst_snpc",  bus.out_snpc, 0);
    chk("rst_perf_f", bus.perf_fetch_cnt,    0);
    chk("rst_perf_r", bus.perf_redirect_cnt, 0);
    chk("rst8_valid", 32'(bus8.out_valid), 0);

    @(negedge clock);
    reset = 1'b0;
    npop = 0; nred = 0;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clock);
      drive(tbl[i].rdy, tbl[i].stl, tbl[i].flg, tbl[i].dnpc);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_req", i),   32'(bus.irom_req),  32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i),  bus.irom_addr, tbl[i].addr);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i),   bus.out_pc,   tbl[i].pc);
        chk($sformatf("tbl%0d_inst", i), bus.out_inst, tbl[i].pc ^ 32'hA5A5_0000);
        chk($sformatf("tbl%0d_snpc", i), bus.out_snpc, tbl[i].pc + 32'd4);
      end
      if (tbl[i].vld && tbl[i].rdy && !tbl[i].stl && !tbl[i].flg) npop++;
      if (tbl[i].flg) nred++;
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("tbl_perf_f", bus.perf_fetch_cnt,    perf_exp(npop));
    chk("tbl_perf_r", bus.perf_redirect_cnt, perf_exp(nred));

    // Asynchronous reset in mid-cycle clears everything immediately.
    @(negedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async_valid",  32'(bus.out_valid), 0);
    chk("async_req",    32'(bus.irom_req),  0);
    chk("async_perf_f", bus.perf_fetch_cnt,    0);
    chk("async_perf_r", bus.perf_redirect_cnt, 0);

    // Random traffic: valid exactly from 4 cycles after the last redirect (reset counts as
    // two cycles of head start), popped PCs consecutive from reset/redirect target.
    @(negedge clock);
    reset = 1'b0;
    age = 2; exp_pc = 32'h0; npop = 0; nred = 0;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge clock);
      rdy = ($urandom % 10) < 7;
      stl = ($urandom % 8) == 0;
      flg = ($urandom % 20) == 0;
      d   = $urandom;
      drive(rdy, stl, flg, d);
      #1;
      ev = (age >= 4);
      chk("rnd_valid", 32'(bus.out_valid), 32'(ev));
      if (flg || age == 1) chk("rnd_req_block", 32'(bus.irom_req), 0);
      if (ev) begin
        chk("rnd_inst", bus.out_inst, bus.out_pc ^ 32'hA5A5_0000);
        chk("rnd_snpc", bus.out_snpc, bus.out_pc + 32'd4);
      end
      if (ev && rdy && !stl && !flg) begin
        chk("rnd_pc", bus.out_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        npop++;
      end
      if (flg) begin
        exp_pc = d & ~32'h3;
        age = 1;
        nred++;
      end else if (age < 100) age++;
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rnd_perf_f", bus.perf_fetch_cnt,    perf_exp(npop));
    chk("rnd_perf_r", bus.perf_redirect_cnt, perf_exp(nred));

    // 8-bit address space: PC and snpc wrap past 0xFC.
    @(negedge clock);
    rst8 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      chk($sformatf("w8_valid%0d", c), 32'(bus8.out_valid), 32'(c >= 2));
      case (c)
        2: chk("w8_pc_f8", 32'(bus8.out_pc), 32'hF8);
        3: begin
          chk("w8_pc_fc",   32'(bus8.out_pc),   32'hFC);
          chk("w8_snpc_fc", 32'(bus8.out_snpc), 32'h00);
        end
        4: begin
          chk("w8_pc_00",   32'(bus8.out_pc), 32'h00);
          chk("w8_inst_00", bus8.out_inst,    32'hA5A5_0000);
        end
        5: chk("w8_pc_04", 32'(bus8.out_pc), 32'h04);
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
